// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with the architectural HI/LO pair.
// Arithmetic ops take WIDTH+1 edges after acceptance; MTHI/MTLO write in one edge.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   mul_step, div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: product's upper half accumulates the multiplicand, multiplier shifts out at the bottom.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: remainder in the upper half, dividend bits shift in while quotient bits fill the bottom.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
  assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d   = op[1];
              neg_d      = a_neg ^ b_neg;
              rem_neg_d  = a_neg;
              div_zero_d = op[1] && (b == {WIDTH{1'b0}});
              a_raw_d    = a;
              acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opb_d      = op[1] ? b_mag : a_mag;
              cnt_d      = '0;
              state_d    = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // Divide-by-zero bypasses the sign fixup so the raw dividend lands in HI.
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = a_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit: WIDTH=32 and WIDTH=8 instances on one clock.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  task automatic applyStimulus(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input bit interfere);
    logic [31:0] hi_prev, lo_prev;
    int          cycles;
    bit          held, early_done;
    hi_prev = hi;
    lo_prev = lo;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cycles = 0; held = 1'b1; early_done = 1'b0;
    while (busy && cycles < 100) begin
      cycles++;
      if (hi !== hi_prev || lo !== lo_prev) held = 1'b0;
      if (done) early_done = 1'b1;
      if (interfere && cycles == 5) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      if (interfere && cycles == 6) begin op = 3'd0; a = 32'd3; b = 32'd3; end
      if (interfere && cycles == 7) start = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, "_hold"}, 64'(held), 64'd1);
    checkOutput({tag, "_early_done"}, 64'(early_done), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic applyStimulus8(input string tag, input logic [2:0] op_i, input logic [7:0] a_i,
                                input logic [7:0] b_i, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    int cycles;
    start8 = 1'b1; op8 = op_i; a8 = a_i; b8 = b_i;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (busy8 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd9);
    checkOutput({tag, "_done"}, 64'(done8), 64'd1);
    checkOutput({tag, "_hi"}, 64'(hi8), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(lo8), 64'(exp_lo));
    @(negedge clk);
  endtask

  task automatic checkPulseEnd(input string tag);
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'({busy, done}), 64'd0);
    checkOutput("reset8", 64'({busy8, done8, hi8, lo8}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    checkPulseEnd("multu_max");
    applyStimulus("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    checkPulseEnd("mult_neg");
    applyStimulus8("multu8", 3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    applyStimulus8("mult8", 3'd0, 8'hFD, 8'h05, 8'hFF, 8'hF1);

    applyStimulus("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    checkPulseEnd("div_neg7_2");
    applyStimulus("divu_20_3", 3'd3, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0);
    checkPulseEnd("divu_20_3");
    applyStimulus("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    checkPulseEnd("div_7_neg2");
    applyStimulus("div_by_zero", 3'd2, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b0);
    checkPulseEnd("div_by_zero");
    applyStimulus("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    checkPulseEnd("div_overflow");

    start = 1'b1; op = 3'd4; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mthi_hi", 64'(hi), 64'h1234);
    checkOutput("mthi_lo", 64'(lo), 64'h8000_0000);
    checkOutput("mthi_flags", 64'({busy, done}), 64'd0);
    start = 1'b1; op = 3'd5; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo_lo", 64'(lo), 64'h5678);
    checkOutput("mtlo_hi", 64'(hi), 64'h1234);
    start = 1'b1; op = 3'd6; a = 32'hFFFF; b = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    checkOutput("reserved_op", 64'({busy, done, hi, lo}), 64'({2'b00, 32'h1234, 32'h5678}));

    applyStimulus("div_interfere", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b1);
    checkPulseEnd("div_interfere");

    applyStimulus("b2b_first", 3'd3, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0);
    applyStimulus("b2b_second", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    checkPulseEnd("b2b_second");

    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 64'(saw_done), 64'd0);
    applyStimulus("divu_after_abort", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    checkPulseEnd("divu_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the MIPS core, with the architectural HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multi-cycle with a start/busy/done handshake, so the single-cycle datapath stalls on it rather than putting a combinational multiplier/divider in the critical path.
- Results feed MFHI/MFLO through the hi/lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width (must be >= 4).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled on the rising edge
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  high while an arithmetic op is in flight
- done  output  1  one-cycle pulse when HI/LO take a new arithmetic result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Reset: hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE. Reset has priority over everything.
- Reset mid-operation aborts the op: no done pulse, HI/LO cleared.

FSM states: IDLE, RUN, FIX.
- IDLE:
  - On edge E0 with start=1 and op in 0-3: latch operands, convert signed operands to magnitudes (ops 0/2), record result signs, counter=0, go to RUN, busy=1.
  - op 4 (MTHI): hi<=a at E0. op 5 (MTLO): lo<=a at E0. Neither sets busy or done.
  - op 6-7: no effect.
- RUN: one radix-2 step per edge, for edges E1..E_WIDTH.
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring; shift remainder, trial-subtract divisor, set quotient bit.
  - Counter increments each step; after step WIDTH, go to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction; write hi/lo; busy<=0; done<=1 for exactly one cycle; return to IDLE.
- Fixed latency for every arithmetic op, including zero operands: WIDTH+1 edges after the accepting edge.
- During busy:
  - hi/lo hold their previous values.
  - start is ignored for all ops, including MTHI/MTLO.
  - a and b may change freely.
- start may be accepted in the same cycle that done=1, because the FSM is already IDLE.
- Multiply results: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product. MULT is signed, MULTU is unsigned.
- Divide results: lo=quotient, hi=remainder.
  - Signed divide truncates toward zero.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a. Same latency, no trap.
- Signed overflow (DIV with a=most-negative, b=-1): lo = most-negative, hi=0.

Test Plan (WIDTH=32 unless noted):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001; hi/lo unchanged before done.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat the MULT and MULTU cases with a WIDTH=8 instance: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=20 b=3 -> lo=6, hi=2. DIV a=7 b=-2 -> lo=0xFFFFFFFD, hi=1.
- DIV a=10 b=0 -> lo=0xFFFFFFFF, hi=0x0000000A, latency 33. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 while idle -> hi=0x1234 after one edge, done stays 0. During a running DIV, MTLO and a new MULT start are ignored; only the original result appears. A back-to-back start on the done cycle is accepted.
- Start DIVU 100/7, assert reset for one edge at iteration 10 -> busy=0, hi=lo=0, no done pulse. A subsequent DIVU 100/7 -> lo=14, hi=2.
